// File: rtl/ldpc_encode_ctrl.sv
// ldpc_encode_ctrl: encodes one info word by feeding each generator column through a single mod2mul, one column per clock
// mod2mul: GF(2) dot product of two K-bit slices
module mod2mul #(
  parameter int SLICE_SIZE = 6
) (
  input  logic [SLICE_SIZE-1:0] a,
  input  logic [SLICE_SIZE-1:0] b,
  output logic                  code_bit
);
  assign code_bit = ^(a & b);
endmodule

module ldpc_encode_ctrl #(
  parameter int N = 11,
  parameter int K = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K-1:0]   info_bits,
  input  logic [N*K-1:0] gen_matrix,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   codeword
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, ENC, HOLD} state_t;
  state_t state_q, state_d;
  logic [K-1:0] info_q;
  logic [CW-1:0] col_cnt;
  logic code_bit;
  logic last;
  assign last = col_cnt == CW'(N - 1);
  mod2mul #(.SLICE_SIZE(K)) u_mul (
    .a        (info_q),
    .b        (gen_matrix[col_cnt*K +: K]),
    .code_bit (code_bit)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state; handshake outputs depend on the state register only
  always_comb begin
    state_d = state_q == IDLE ? (in_valid ? ENC : IDLE) :
              state_q == ENC  ? (last ? HOLD : ENC) :
                                (out_ready ? IDLE : HOLD);
    in_ready = state_q == IDLE;
    busy = state_q == ENC || state_q == HOLD;
    out_valid = state_q == HOLD;
  end
  // latch the info word on accept, then fill one codeword bit per ENC cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      info_q <= '0;
      codeword <= '0;
      col_cnt <= '0;
    end else if (state_q == IDLE && in_valid) begin
      info_q <= info_bits;
      codeword <= '0;
      col_cnt <= '0;
    end else if (state_q == ENC) begin
      codeword[col_cnt] <= code_bit;
      col_cnt <= last ? '0 : col_cnt + 1'b1;
    end
endmodule
